// File: rtl/ahbl_sram_responder_if.sv
// AHB-Lite responder-side bus bundle: address/control, write data, read data and handshake.
// Latency: none, wires only.
// Backpressure: carries the bus-wide HREADY in and this responder's HREADYOUT back.
interface ahbl_sram_responder_if;
    logic        ahbls_hready;
    logic        ahbls_hready_resp;
    logic        ahbls_hresp;
    logic [31:0] ahbls_haddr;
    logic        ahbls_hwrite;
    logic [1:0]  ahbls_htrans;
    logic [2:0]  ahbls_hsize;
    logic        ahbls_hsel;
    logic [31:0] ahbls_hwdata;
    logic [31:0] ahbls_hrdata;

    modport master (
        output ahbls_hready, ahbls_haddr, ahbls_hwrite, ahbls_htrans,
               ahbls_hsize, ahbls_hsel, ahbls_hwdata,
        input  ahbls_hready_resp, ahbls_hresp, ahbls_hrdata
    );

    modport slave (
        input  ahbls_hready, ahbls_haddr, ahbls_hwrite, ahbls_htrans,
               ahbls_hsize, ahbls_hsel, ahbls_hwdata,
        output ahbls_hready_resp, ahbls_hresp, ahbls_hrdata
    );
endinterface

// File: rtl/ahbl_sram_responder.sv
// AHB-Lite word SRAM responder with byte lanes and optional out-of-range ERROR (macro AHBL_SRAM_ERROR_EN).
// Latency: STALL_CYCLES+1 cycles per OKAY data phase, 2 cycles per ERROR data phase.
// Backpressure: drives hready_resp low for STALL_CYCLES cycles (or the first ERROR cycle) of each data phase.
module ahbl_sram_responder #(
    parameter int          DEPTH        = 1024,
    parameter int          STALL_CYCLES = 0,
    parameter logic [31:0] BASE         = 32'h0
) (
    input  logic                     clk,
    input  logic                     rst,
    ahbl_sram_responder_if.slave     bus
);
    localparam int AW = $clog2(DEPTH * 4);
    localparam int IW = AW - 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STALL = 2'd1
`ifdef AHBL_SRAM_ERROR_EN
        ,
        ST_ERR   = 2'd2
`endif
    } state_t;

    state_t          state, state_nxt;
    logic [3:0]      stall_cnt, stall_cnt_nxt;
    logic            hready_resp;
    logic            pend_vld;
    logic            pend_wr;
    logic [IW-1:0]   pend_idx;
    logic [3:0]      pend_mask;
    logic [31:0]     hrdata_q;
    logic [31:0]     mem [DEPTH];

    logic            accept;
    logic [IW-1:0]   addr_idx;
    logic [3:0]      addr_mask;
    logic            addr_err;
    logic            pend_ok;
    logic            complete;
    logic            wr_commit;
    logic [31:0]     rd_word;
    logic [31:0]     rd_fwd;

    // Address phases are only taken while this responder is not stretching a data phase.
    assign accept   = bus.ahbls_hready && bus.ahbls_hsel && bus.ahbls_htrans[1] && (state == ST_IDLE);
    assign addr_idx = bus.ahbls_haddr[AW-1:2];

`ifdef AHBL_SRAM_ERROR_EN
    logic pend_err;
    logic hresp;
    // Out of range means the address bits above the array window do not match BASE.
    assign addr_err = (bus.ahbls_haddr & ~32'(DEPTH * 4 - 1)) != BASE;
    assign pend_ok  = !pend_err;
    assign bus.ahbls_hresp = hresp;
    logic unused_sigs;
    assign unused_sigs = bus.ahbls_htrans[0];
`else
    // Without the error feature upper address bits simply alias onto the array.
    assign addr_err = 1'b0;
    assign pend_ok  = 1'b1;
    assign bus.ahbls_hresp = 1'b0;
    logic unused_sigs;
    assign unused_sigs = ^{bus.ahbls_htrans[0], bus.ahbls_haddr[31:AW], BASE, addr_err};
`endif

    // Lane mask: misaligned halfword/word addresses fall back to their aligned lanes.
    always_comb begin
        addr_mask = 4'hf;
        case (bus.ahbls_hsize)
            3'd0:    addr_mask = 4'b0001 << bus.ahbls_haddr[1:0];
            3'd1:    addr_mask = bus.ahbls_haddr[1] ? 4'b1100 : 4'b0011;
            default: addr_mask = 4'hf;
        endcase
    end

    // A data phase ends on the cycle hready_resp is high; errored writes never commit.
    assign complete  = pend_vld && hready_resp;
    assign wr_commit = complete && pend_wr && pend_ok;

    // Read path with forwarding of a write committing on the same edge to the same word.
    always_comb begin
        rd_word = mem[addr_idx];
        rd_fwd  = rd_word;
        if (wr_commit && (pend_idx == addr_idx)) begin
            for (int b = 0; b < 4; b++) begin
                if (pend_mask[b]) rd_fwd[b*8 +: 8] = bus.ahbls_hwdata[b*8 +: 8];
            end
        end
    end

    // Next-state and response outputs.
    always_comb begin
        state_nxt     = state;
        stall_cnt_nxt = stall_cnt;
        hready_resp   = 1'b1;
`ifdef AHBL_SRAM_ERROR_EN
        hresp         = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
`ifdef AHBL_SRAM_ERROR_EN
                // Second ERROR cycle: IDLE outputs with the errored access still pending.
                hresp = pend_vld && pend_err;
                if (accept && addr_err) begin
                    state_nxt = ST_ERR;
                end else
`endif
                if (accept && (STALL_CYCLES > 0)) begin
                    state_nxt     = ST_STALL;
                    stall_cnt_nxt = 4'(STALL_CYCLES - 1);
                end
            end
            ST_STALL: begin
                hready_resp = 1'b0;
                if (stall_cnt == 4'd0) state_nxt = ST_IDLE;
                else                   stall_cnt_nxt = stall_cnt - 4'd1;
            end
`ifdef AHBL_SRAM_ERROR_EN
            ST_ERR: begin
                hready_resp = 1'b0;
                hresp       = 1'b1;
                state_nxt   = ST_IDLE;
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State, pending access capture and registered read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            stall_cnt <= 4'd0;
            pend_vld  <= 1'b0;
            hrdata_q  <= 32'h0;
`ifdef AHBL_SRAM_ERROR_EN
            pend_err  <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            stall_cnt <= stall_cnt_nxt;
            if (accept) begin
                pend_vld  <= 1'b1;
                pend_wr   <= bus.ahbls_hwrite;
                pend_idx  <= addr_idx;
                pend_mask <= addr_mask;
`ifdef AHBL_SRAM_ERROR_EN
                pend_err  <= addr_err;
`endif
                if (!bus.ahbls_hwrite) hrdata_q <= addr_err ? 32'h0 : rd_fwd;
            end else if (complete) begin
                pend_vld <= 1'b0;
            end
        end
    end

    // Byte-lane write commit at the end of the data phase; memory is never reset.
    always_ff @(posedge clk) begin
        if (!rst && wr_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (pend_mask[b]) mem[pend_idx][b*8 +: 8] <= bus.ahbls_hwdata[b*8 +: 8];
            end
        end
    end

    assign bus.ahbls_hready_resp = hready_resp;
    assign bus.ahbls_hrdata      = hrdata_q;
endmodule
